data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares the single-port synchronous data memory between two requesters: port 0 (processor load/store path) and port 1 (boot loader / debug DMA). Each transaction is accepted through a valid/ready handshake, registered, issued to memory, and answered with a one-cycle response pulse. The block sits between the processor's memory outputs (address/ALU result, write data, write strobe, read data) and the data memory instance. The processor uses port 0 `ready` as its stall condition.

## Interface
- `DATA_WIDTH`, 8: data word width.
- `ADDR_WIDTH`, 8: memory address width.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-port request valid; bit i = port i.
- `req_ready`  out  2  per-port accept; handshake when valid[i] && ready[i].
- `req_we0`, `req_we1`  in  1  write request (1) / read request (0).
- `req_addr0`, `req_addr1`  in  ADDR_WIDTH  request address.
- `req_wdata0`, `req_wdata1`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  2  one-cycle response pulse to the granted port.
- `rsp_rdata`  out  DATA_WIDTH  read data; valid only with `rsp_valid`.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_we`  out  1  memory write strobe.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid one cycle after address.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - The picker selects at most one port among the asserted `req_valid` bits.
  - `req_ready[sel]=1`; all other ready bits are 0.
  - On handshake: capture we/addr/wdata and the port index into the command register, then go to ISSUE.
  - With no valid requests, stay in IDLE.
- **ISSUE**
  - Drive `mem_addr`/`mem_wdata` from the command register.
  - `mem_we` = captured we, for this cycle only.
  - Go to RESP.
- **RESP**
  - Pulse `rsp_valid[port]=1`.
  - `rsp_rdata` = `mem_rdata` for reads, 0 for writes.
  - Go to IDLE.
- `req_ready` is 0 in ISSUE and RESP. The next acceptance is therefore possible in the cycle after RESP.
- Requesters hold valid and payload stable until the handshake. Dropping valid before the handshake is legal, and nothing is captured.
- Outside ISSUE, `mem_we`=0 and `mem_addr`/`mem_wdata` hold the last command-register values.
- Port selection (fixed priority by default):
  - port 0 wins when both ports are valid;
  - port 1 is granted only when `req_valid[0]=0`.
- No address or data arithmetic is performed; all fields pass through at full width.

## Timing
- Reset (asynchronous):
  - state=IDLE, command register=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `rsp_valid`=0, `rsp_rdata`=0;
  - RR pointer (when compiled in) = port 0.
- `req_ready` is combinational from state and `req_valid`, with no added latency in IDLE.
- Latency: handshake in cycle N → memory access in N+1 → `rsp_valid` in N+2 → next handshake no earlier than N+3. Peak throughput is 1 transaction per 3 cycles.
- Reset asserted in ISSUE: `mem_we` deasserts immediately, and no write is committed past the reset edge. The pending response is discarded.
- Reset asserted in RESP: `rsp_valid` clears immediately.
- A simultaneous request from the port just serviced and the other port is resolved by the policy only.

## Configuration
- `DATA_MEM_ARB_RR_EN` defined:
  - round-robin selection; a 1-bit pointer marks the preferred port;
  - when both ports are valid in IDLE, the preferred port wins;
  - the pointer moves to the other port after every handshake;
  - with only one port valid, that port wins regardless of the pointer.
- Undefined: fixed priority (port 0 first); no pointer register exists.

## Structure
- Package `data_mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, RESP};
  - `port_idx_t` (1-bit port index);
  - `NUM_PORTS=2`.
- Sub-module `data_mem_arb_pick`: combinational picker taking `req_valid` and the pointer, producing `sel` and `any_valid`. The RR/fixed policy difference is confined to this sub-module plus the pointer register.

## Test plan
- **Single read:** port 0 read addr 0x10, memory holds 0xA5 → `req_ready[0]` high in IDLE, `mem_addr`=0x10 in N+1, `rsp_valid`=2'b01 with `rsp_rdata`=0xA5 in N+2.
- **Write then read:** port 1 writes 0x3C to 0x20 → `mem_we`=1 for exactly one cycle; the following port 1 read of 0x20 returns 0x3C; `rsp_rdata`=0 on the write response.
- **Contention, fixed priority:** both ports valid continuously → port 0 granted every transaction; port 1 is granted only after `req_valid[0]` drops.
- **Contention, `DATA_MEM_ARB_RR_EN` defined:** both ports valid continuously for 4 transactions → grants alternate 0,1,0,1; one grant every 3 cycles.
- **Reset mid-write:** assert `reset` during ISSUE of a write to 0x30 → `mem_we` falls asynchronously, no `rsp_valid`, FSM in IDLE, all outputs 0 after release.
- **Valid withdrawn:** port 1 valid for 1 cycle while port 0 holds the grant, then dropped → no port 1 capture and no `rsp_valid[1]`.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data memory arbiter: FSM states, port index and port count.
package data_mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_pick.sv
// Combinational port picker: the preferred port (ptr) wins only when both ports are valid.
// A constant-zero ptr yields fixed priority to port 0.
module data_mem_arb_pick
    import data_mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_valid,
    input  port_idx_t            ptr,
    output port_idx_t            sel,
    output logic                 any_valid
);

    // select the preferred port under contention, otherwise the only valid one
    always_comb begin
        any_valid = |req_valid;
        if (&req_valid) begin
            sel = ptr;
        end else begin
            sel = req_valid[1];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory (IDLE -> ISSUE -> RESP).
// Build option: define DATA_MEM_ARB_RR_EN for round-robin selection instead of fixed priority.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PORTS-1:0]  req_valid,
    output logic [NUM_PORTS-1:0]  req_ready,
    input  logic                  req_we0,
    input  logic                  req_we1,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [NUM_PORTS-1:0]  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  r_cmd_we;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_wdata;
    port_idx_t             r_cmd_port;
    logic                  r_mem_we;
    logic [NUM_PORTS-1:0]  r_rsp_valid;

    port_idx_t             w_ptr;
    port_idx_t             w_sel;
    logic                  w_any_valid;
    logic                  w_hs;
    logic [NUM_PORTS-1:0]  w_ready;
    logic [DATA_WIDTH-1:0] w_rsp_rdata;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

`ifdef DATA_MEM_ARB_RR_EN
    port_idx_t r_ptr;

    // preferred port flips after every accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_hs) begin
            r_ptr <= ~r_ptr;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    data_mem_arb_pick u_pick (
        .req_valid (req_valid),
        .ptr       (w_ptr),
        .sel       (w_sel),
        .any_valid (w_any_valid)
    );

    assign w_sel_we    = w_sel ? req_we1    : req_we0;
    assign w_sel_addr  = w_sel ? req_addr1  : req_addr0;
    assign w_sel_wdata = w_sel ? req_wdata1 : req_wdata0;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next state, ready and read-data steering
    always_comb begin
        w_next_state = r_state;
        w_ready      = {NUM_PORTS{1'b0}};
        w_hs         = 1'b0;
        w_rsp_rdata  = {DATA_WIDTH{1'b0}};
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_ready      = port_onehot(w_sel);
                    w_hs         = 1'b1;
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                w_next_state = RESP;
            end
            RESP: begin
                // the memory answers one cycle after the address, i.e. now
                if (!r_cmd_we) begin
                    w_rsp_rdata = mem_rdata;
                end else begin
                    w_rsp_rdata = {DATA_WIDTH{1'b0}};
                end
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // command register, write strobe and response pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= {ADDR_WIDTH{1'b0}};
            r_cmd_wdata <= {DATA_WIDTH{1'b0}};
            r_cmd_port  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= {NUM_PORTS{1'b0}};
        end else begin
            if (w_hs) begin
                r_cmd_we    <= w_sel_we;
                r_cmd_addr  <= w_sel_addr;
                r_cmd_wdata <= w_sel_wdata;
                r_cmd_port  <= w_sel;
                r_mem_we    <= w_sel_we;
            end else begin
                r_mem_we    <= 1'b0;
            end
            if (r_state == ISSUE) begin
                r_rsp_valid <= port_onehot(r_cmd_port);
            end else begin
                r_rsp_valid <= {NUM_PORTS{1'b0}};
            end
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = w_rsp_rdata;
    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;
    assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests push expected responses, a monitor pops and compares.
module tb_data_mem_arbiter;

    typedef struct {
        int         port;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic       req_we0, req_we1;
    logic [7:0] req_addr0, req_addr1;
    logic [7:0] req_wdata0, req_wdata1;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];
    logic       mem_init;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   hs_cyc  = 0;
    bit   rr_ptr  = 1'b0;

    data_mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we0    (req_we0),
        .req_we1    (req_we1),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // single-port synchronous memory, read-before-write
    always @(posedge clk) begin
        if (mem_init) begin
            mem[8'h10] <= 8'hA5;
            mem[8'h20] <= 8'h00;
            mem[8'h30] <= 8'h11;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every response pulse must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_port", {30'd0, rsp_valid}, (e.port == 1) ? 32'd2 : 32'd1);
                check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
            end
        end
    end

    task automatic set_port(input int p, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        if (p == 0) begin
            req_we0 = we; req_addr0 = addr; req_wdata0 = wdata;
        end else begin
            req_we1 = we; req_addr1 = addr; req_wdata1 = wdata;
        end
    endtask

    task automatic push_exp(input int p, input logic [7:0] rd);
        exp_t e;
        e.port  = p;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    // returns #1 after the capturing edge (in ISSUE); bounded
    task automatic wait_hs(output int port);
        bit ok = 1'b0;
        port = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 2'b00) begin
                port = req_ready[1] ? 1 : 0;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            check("hs_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            hs_cyc = cyc;
            rr_ptr = ~rr_ptr;
        end
    endtask

    task automatic single(input int p, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd);
        int got;
        set_port(p, we, addr, wdata);
        req_valid[p] = 1'b1;
        #1;
        check("ready_idle", {30'd0, req_ready}, (p == 1) ? 32'd2 : 32'd1);
        wait_hs(got);
        req_valid[p] = 1'b0;
        check("grant", got, p);
        push_exp(p, we ? 8'h00 : exp_rd);
        check("issue_addr", {24'd0, mem_addr}, {24'd0, addr});
        check("issue_we", {31'd0, mem_we}, {31'd0, we});
        check("issue_wdata", {24'd0, mem_wdata}, {24'd0, wdata});
        @(posedge clk); #1;
        check("we_one_cycle", {31'd0, mem_we}, 32'd0);
        check("ready_resp", {30'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        int got;
        int exp_p;
        int prev;
        reset = 1'b1; mem_init = 1'b1; req_valid = 2'b00;
        set_port(0, 1'b0, 8'h00, 8'h00);
        set_port(1, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_init = 1'b0; rr_ptr = 1'b0;
        @(posedge clk); #1;

        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_ready", {30'd0, req_ready}, 32'd0);

        // single read, then port 1 write and read-back
        single(0, 1'b0, 8'h10, 8'h00, 8'hA5);
        single(1, 1'b1, 8'h20, 8'h3C, 8'h00);
        single(1, 1'b0, 8'h20, 8'h00, 8'h3C);

        // contention: both ports valid continuously
        set_port(0, 1'b0, 8'h10, 8'h00);
        set_port(1, 1'b0, 8'h20, 8'h00);
        req_valid = 2'b11;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef DATA_MEM_ARB_RR_EN
            exp_p = rr_ptr ? 1 : 0;
`else
            exp_p = (k < 3) ? 0 : 1;
`endif
            wait_hs(got);
            check("contend_grant", got, exp_p);
            push_exp(exp_p, (exp_p == 1) ? 8'h3C : 8'hA5);
            if (k > 0) begin
                check("contend_spacing", hs_cyc - prev, 32'd3);
            end
            prev = hs_cyc;
`ifndef DATA_MEM_ARB_RR_EN
            if (k == 2) begin
                req_valid[0] = 1'b0;
            end
`endif
        end
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // reset during ISSUE of a write: nothing committed, no response
        set_port(0, 1'b1, 8'h30, 8'h77);
        req_valid[0] = 1'b1;
        wait_hs(got);
        req_valid = 2'b00;
        check("rst_issue_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_we", {31'd0, mem_we}, 32'd0);
        rr_ptr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_mem_we", {31'd0, mem_we}, 32'd0);
        check("rel_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rel_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rel_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rel_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rel_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        single(0, 1'b0, 8'h30, 8'h00, 8'h11);

        // port 1 valid for one cycle while port 0 holds the grant
        set_port(0, 1'b0, 8'h10, 8'h00);
        set_port(1, 1'b1, 8'h20, 8'hEE);
        req_valid = 2'b01;
        wait_hs(got);
        check("wd_grant", got, 0);
        push_exp(0, 8'hA5);
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        single(1, 1'b0, 8'h20, 8'h00, 8'h3C);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
